round_key_store: RTL and testbench

//  - Downstream of key expansion: captures each 128-bit round key as it is produced and holds all NUM_ROUNDS+1 keys.
//  - Random-access read port lets the cipher/inverse-cipher core fetch keys in any order (reverse order for decryption).
//  - Tracks which entries are valid; flags when the full schedule is present.

---
 rtl/round_key_store.sv | 139 +++++++++++++
 tb/tb_round_key_store.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/round_key_store.sv
// Round-key store: captures the NUM_ROUNDS+1 expanded AES round keys and serves them over a registered random-access read port.
// Optional build macro ROUND_KEY_STORE_ZEROIZE_EN adds a storage-clearing sweep on zeroize.
module round_key_store #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_ROUNDS = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              FSM_core_in,
    input  logic [3:0]              core_count_in,
    input  logic [DATA_WIDTH-1:0]   key_in_0,
    input  logic [DATA_WIDTH-1:0]   key_in_1,
    input  logic [DATA_WIDTH-1:0]   key_in_2,
    input  logic [DATA_WIDTH-1:0]   key_in_3,
    input  logic                    rd_en,
    input  logic [3:0]              rd_addr,
    input  logic                    zeroize,
    output logic [4*DATA_WIDTH-1:0] rd_key,
    output logic                    rd_valid,
    output logic                    rd_miss,
    output logic                    keys_ready,
    output logic                    busy
);
    localparam int         KW    = 4 * DATA_WIDTH;
    localparam int         DEPTH = NUM_ROUNDS + 1;
    localparam logic [3:0] LAST  = 4'(NUM_ROUNDS);
    localparam logic [2:0] CORE_LOAD   = 3'b001;
    localparam logic [2:0] CORE_EXPAND = 3'b010;

`ifdef ROUND_KEY_STORE_ZEROIZE_EN
    typedef enum logic [1:0] {S_EMPTY, S_FILLING, S_FULL, S_ZEROIZE} state_e;
`else
    typedef enum logic [1:0] {S_EMPTY, S_FILLING, S_FULL} state_e;
`endif

    state_e           state_q, state_d;
    logic [DEPTH-1:0] mask_q, mask_d;
    logic [KW-1:0]    mem_q [DEPTH];
    logic             wr_en;
    logic [3:0]       wr_idx;
    logic [KW-1:0]    wr_data;
    logic             sweep;
    logic             rd_hit;
    logic [KW-1:0]    rd_key_q;
    logic             rd_valid_q, rd_miss_q, keys_ready_q;

`ifdef ROUND_KEY_STORE_ZEROIZE_EN
    logic [3:0] zidx_q, zidx_d;
    logic       busy_q;
    assign sweep = (state_q == S_ZEROIZE);
`else
    assign sweep = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        wr_en   = 1'b0;
        wr_idx  = core_count_in;
        wr_data = {key_in_0, key_in_1, key_in_2, key_in_3};
`ifdef ROUND_KEY_STORE_ZEROIZE_EN
        zidx_d  = zidx_q;
        if (sweep) begin
            // One entry cleared per cycle; loads and expansion writes are locked out.
            wr_en   = 1'b1;
            wr_idx  = zidx_q;
            wr_data = '0;
            zidx_d  = zidx_q + 4'd1;
            if (zidx_q == LAST) begin
                state_d = S_EMPTY;
                zidx_d  = '0;
            end
        end else if (zeroize) begin
            state_d = S_ZEROIZE;
            mask_d  = '0;
            zidx_d  = '0;
        end else
`else
        if (zeroize) begin
            state_d = S_EMPTY;
            mask_d  = '0;
        end else
`endif
        if (FSM_core_in == CORE_LOAD) begin
            state_d = S_EMPTY;
            mask_d  = '0;
        end else if (FSM_core_in == CORE_EXPAND && core_count_in <= LAST) begin
            wr_en                 = 1'b1;
            mask_d[core_count_in] = 1'b1;
            state_d               = (&mask_d) ? S_FULL : S_FILLING;
        end
    end

    // Read looks at pre-edge mask/storage, giving read-before-write on a collision.
    assign rd_hit = rd_en && !sweep && (rd_addr <= LAST) && mask_q[rd_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_EMPTY;
            mask_q       <= '0;
            rd_key_q     <= '0;
            rd_valid_q   <= 1'b0;
            rd_miss_q    <= 1'b0;
            keys_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            rd_valid_q   <= rd_hit;
            rd_miss_q    <= rd_en && !rd_hit;
            keys_ready_q <= (state_d == S_FULL);
            if (rd_hit) rd_key_q <= mem_q[rd_addr];
        end
    end

`ifdef ROUND_KEY_STORE_ZEROIZE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zidx_q <= '0;
            busy_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            zidx_q <= zidx_d;
            busy_q <= (state_d == S_ZEROIZE);
            if (wr_en) mem_q[wr_idx] <= wr_data;
        end
    end
    assign busy = busy_q;
`else
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= wr_data;
    end
    assign busy = 1'b0;
`endif

    assign rd_key     = rd_key_q;
    assign rd_valid   = rd_valid_q;
    assign rd_miss    = rd_miss_q;
    assign keys_ready = keys_ready_q;
endmodule

// File: tb/tb_round_key_store.sv
// Scoreboard bench for round_key_store using the FIPS-197 A.1 AES-128 key schedule.
module tb_round_key_store;
    logic         clk, rst_n;
    logic [2:0]   fsm;
    logic [3:0]   cnt;
    logic [127:0] wkey;
    logic         rd_en;
    logic [3:0]   rd_addr;
    logic         zeroize;
    logic [127:0] rd_key;
    logic         rd_valid, rd_miss, keys_ready, busy;

    localparam logic [127:0] K [11] = '{
        128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
        128'ha0fafe17_88542cb1_23a33939_2a6c7605,
        128'hf2c295f2_7a96b943_5935807a_7359f67f,
        128'h3d80477d_4716fe3e_1e237e44_6d7a883b,
        128'hef44a541_a8525b7f_b671253b_db0bad00,
        128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc,
        128'h6d88a37a_110b3efd_dbf98641_ca0093fd,
        128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f,
        128'head27321_b58dbad2_312bf560_7f8d292f,
        128'hac7766f3_19fadc21_28d12941_575c006e,
        128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6
    };
    localparam logic [127:0] JUNK = 128'hdeadbeef_01234567_89abcdef_cafef00d;

    round_key_store dut (
        .clk(clk), .rst_n(rst_n), .FSM_core_in(fsm), .core_count_in(cnt),
        .key_in_0(wkey[127:96]), .key_in_1(wkey[95:64]), .key_in_2(wkey[63:32]), .key_in_3(wkey[31:0]),
        .rd_en(rd_en), .rd_addr(rd_addr), .zeroize(zeroize),
        .rd_key(rd_key), .rd_valid(rd_valid), .rd_miss(rd_miss), .keys_ready(keys_ready), .busy(busy)
    );

    typedef struct packed {logic v; logic m; logic [127:0] k;} exp_t;
    exp_t         sbq[$];
    int           vectors = 0;
    int           miscompares = 0;
    logic [127:0] last_key;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (rd_valid || rd_miss)) begin
            if (sbq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rd_unexpected got valid=%b miss=%b exp no response", rd_valid, rd_miss);
            end else begin
                e = sbq.pop_front();
                chk("rd_valid", 128'(rd_valid), 128'(e.v));
                chk("rd_miss", 128'(rd_miss), 128'(e.m));
                chk("rd_key", rd_key, e.k);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic hit, input int a);
        if (hit) last_key = K[a];
        sbq.push_back('{v: hit, m: !hit, k: last_key});
    endtask

    task automatic wr_raw(input logic [3:0] c, input logic [127:0] k);
        fsm = 3'b010; cnt = c; wkey = k;
        cyc();
        fsm = 3'b000;
    endtask

    task automatic wr(input int i);
        wr_raw(4'(i), K[i]);
    endtask

    task automatic rd(input int a, input logic hit);
        rd_en = 1'b1; rd_addr = 4'(a);
        push(hit, a);
        cyc();
        rd_en = 1'b0;
    endtask

    task automatic load();
        fsm = 3'b001;
        cyc();
        fsm = 3'b000;
    endtask

    task automatic fill();
        load();
        for (int i = 0; i <= 10; i++) wr(i);
        chk("keys_ready_fill", 128'(keys_ready), 128'(1));
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_rd_key"}, rd_key, '0);
        chk({tag, "_rd_valid"}, 128'(rd_valid), '0);
        chk({tag, "_rd_miss"}, 128'(rd_miss), '0);
        chk({tag, "_keys_ready"}, 128'(keys_ready), '0);
        chk({tag, "_busy"}, 128'(busy), '0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; fsm = '0; cnt = '0; wkey = '0; rd_en = 1'b0; rd_addr = '0; zeroize = 1'b0;
        last_key = '0;
        #3;
        chk_outs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Full fill with count 0 held twice and an out-of-range write before the last key.
        load();
        wr_raw(4'd0, JUNK);
        for (int i = 0; i <= 9; i++) wr(i);
        wr_raw(4'd11, JUNK);
        chk("keys_ready_before_last", 128'(keys_ready), '0);
        wr(10);
        chk("keys_ready_after_last", 128'(keys_ready), 128'(1));
        rd(1, 1'b1);
        rd(10, 1'b1);
        rd(0, 1'b1);

        // Reverse order, back to back.
        for (int a = 10; a >= 0; a--) rd(a, 1'b1);
        rd(12, 1'b0);

        // Reload clears the valid mask.
        load();
        chk("keys_ready_reload", 128'(keys_ready), '0);
        rd(0, 1'b0);

        // Partial fill, miss, and same-cycle first write/read.
        for (int i = 0; i <= 3; i++) wr(i);
        rd(5, 1'b0);
        fsm = 3'b010; cnt = 4'd4; wkey = K[4]; rd_en = 1'b1; rd_addr = 4'd4;
        push(1'b0, 4);
        cyc();
        fsm = 3'b000; rd_en = 1'b0;
        rd(4, 1'b1);
        for (int i = 5; i <= 10; i++) wr(i);
        chk("keys_ready_partial_done", 128'(keys_ready), 128'(1));

        // Reset mid-fill.
        load();
        for (int i = 0; i <= 6; i++) wr(i);
        rd(3, 1'b1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_outs_zero("midreset");
        last_key = '0;
        #2;
        rst_n = 1'b1;
        cyc();
        rd(3, 1'b0);
        fill();
        rd(6, 1'b1);

`ifdef ROUND_KEY_STORE_ZEROIZE_EN
        zeroize = 1'b1;
        cyc();
        zeroize = 1'b0;
        chk("keys_ready_zeroize", 128'(keys_ready), '0);
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            if (n == 5) begin fsm = 3'b010; cnt = 4'd2; wkey = JUNK; end
            else fsm = 3'b000;
            cyc();
        end
        fsm = 3'b000;
        chk("busy_cycles", 128'(n), 128'(11));
        for (int a = 0; a <= 10; a++) rd(a, 1'b0);
        fill();
        rd(0, 1'b1);
`else
        zeroize = 1'b1;
        cyc();
        zeroize = 1'b0;
        chk("keys_ready_zeroize", 128'(keys_ready), '0);
        chk("busy_tied", 128'(busy), '0);
        rd(1, 1'b0);
        fill();
        rd(1, 1'b1);
`endif

        repeat (3) cyc();
        chk("sb_drain", 128'(sbq.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
